// File: rtl/tsp_pkg.sv
// Shared types and index helpers for the TSP path lock arbiter.
package tsp_pkg;
  localparam int PATH_LEN = 64;
  localparam int IDX_W    = 6;

  typedef enum logic {MODE_PAIR = 1'b0, MODE_ADJ = 1'b1} lock_mode_t;
  typedef enum logic {ST_RR = 1'b0, ST_AGED = 1'b1} arb_state_t;

  // Path positions wrap naturally in 6 bits; an offset of all-ones means -1.
  function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    return base + off;
  endfunction
endpackage

// File: rtl/path_lock_arbiter_if.sv
// Solver-side request/release bus and arbiter status outputs.
interface path_lock_arbiter_if
  import tsp_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic                            flush;
  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_mode;
  logic [N_REQ-1:0][IDX_W-1:0]     req_v1;
  logic [N_REQ-1:0][IDX_W-1:0]     req_v2;
  logic [N_REQ-1:0]                rel_valid;
  logic [N_REQ-1:0]                grant;
  logic [N_REQ-1:0]                err;
  logic [N_REQ-1:0]                held;
  logic [PATH_LEN-1:0]             lock_busy;
  logic [31:0]                     grant_count;

  modport master (
    output flush, req_valid, req_mode, req_v1, req_v2, rel_valid,
    input  grant, err, held, lock_busy, grant_count
  );

  modport slave (
    input  flush, req_valid, req_mode, req_v1, req_v2, rel_valid,
    output grant, err, held, lock_busy, grant_count
  );
endinterface

// File: rtl/lock_mask_gen.sv
// Converts one solver request into the set of path positions it must lock.
module lock_mask_gen
  import tsp_pkg::*;
(
  input  logic                mode_i,
  input  logic [IDX_W-1:0]    v1_i,
  input  logic [IDX_W-1:0]    v2_i,
  output logic [PATH_LEN-1:0] mask_o,
  output logic                invalid_o
);
  localparam logic [IDX_W-1:0] MINUS1 = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] PLUS1  = IDX_W'(1);

  always_comb begin
    mask_o    = '0;
    invalid_o = 1'b0;
    if (mode_i == MODE_ADJ) begin
      for (int k = 0; k < 4; k++) begin
        mask_o[idx_wrap(v1_i, IDX_W'(k))] = 1'b1;
      end
    end else begin
      mask_o[idx_wrap(v1_i, MINUS1)] = 1'b1;
      mask_o[v1_i]                   = 1'b1;
      mask_o[idx_wrap(v1_i, PLUS1)]  = 1'b1;
      mask_o[idx_wrap(v2_i, MINUS1)] = 1'b1;
      mask_o[v2_i]                   = 1'b1;
      mask_o[idx_wrap(v2_i, PLUS1)]  = 1'b1;
      // Equal or neighbouring pair vertices cannot form a 2-opt style swap.
      invalid_o = (v1_i == v2_i) || (v2_i == idx_wrap(v1_i, PLUS1)) ||
                  (v1_i == idx_wrap(v2_i, PLUS1));
    end
  end
endmodule

// File: rtl/path_lock_arbiter.sv
// Atomic window lock manager: round-robin grant with an aging override.
module path_lock_arbiter
  import tsp_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_WAIT = 15
) (
  input logic               clk,
  input logic               rst,
  path_lock_arbiter_if.slave bus
);
  localparam int OWN_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [PATH_LEN-1:0] mask [N_REQ];
  logic [N_REQ-1:0]    inv;

  for (genvar g = 0; g < N_REQ; g++) begin : g_mask
    lock_mask_gen u_mask (
      .mode_i   (bus.req_mode[g]),
      .v1_i     (bus.req_v1[g]),
      .v2_i     (bus.req_v2[g]),
      .mask_o   (mask[g]),
      .invalid_o(inv[g])
    );
  end

  arb_state_t          state_q, state_d;
  logic [OWN_W-1:0]    aged_q, aged_d;
  logic [OWN_W-1:0]    rr_q, rr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    err_q, err_d;
  logic [N_REQ-1:0]    held_q, held_d;
  logic [PATH_LEN-1:0] lock_busy_q, lock_busy_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q [N_REQ];
  logic [WAIT_W-1:0]   wait_d [N_REQ];
  logic [OWN_W-1:0]    owner_q [PATH_LEN];
  logic [OWN_W-1:0]    owner_d [PATH_LEN];

  logic [N_REQ-1:0]    elig, rel_act;
  logic [PATH_LEN-1:0] rel_pos, gmask;
  logic                win_vld;
  logic [OWN_W-1:0]    win;

  always_comb begin
    elig    = '0;
    err_d   = '0;
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i]  = bus.req_valid[i] && !held_q[i] && !inv[i] &&
                 ((mask[i] & lock_busy_q) == '0);
      err_d[i] = bus.req_valid[i] && !held_q[i] && inv[i];
    end

    if (state_q == ST_RR) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!win_vld && elig[(int'(rr_q) + k) % N_REQ]) begin
          win_vld = 1'b1;
          win     = OWN_W'((int'(rr_q) + k) % N_REQ);
        end
      end
    end else if (elig[aged_q]) begin
      win_vld = 1'b1;
      win     = aged_q;
    end

    grant_d = win_vld ? (N_REQ'(1) << win) : '0;
    gmask   = win_vld ? mask[win] : '0;
    rel_act = bus.rel_valid & held_q;
    owner_d = owner_q;
    for (int p = 0; p < PATH_LEN; p++) begin
      rel_pos[p] = lock_busy_q[p] && rel_act[owner_q[p]];
      if (gmask[p]) owner_d[p] = win;
    end
    // Granted and released sets are disjoint, so both updates apply.
    lock_busy_d = (lock_busy_q & ~rel_pos) | gmask;
    held_d      = (held_q & ~rel_act) | grant_d;
    cnt_d       = cnt_q + 32'(win_vld);

    rr_d = rr_q;
    if (state_q == ST_RR && win_vld) begin
      rr_d = (win == OWN_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (!bus.req_valid[i] || held_q[i] || inv[i] || grant_d[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_MAX) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end

    state_d = state_q;
    aged_d  = aged_q;
    if (state_q == ST_RR) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (wait_d[i] == WAIT_MAX) begin
          state_d = ST_AGED;
          aged_d  = OWN_W'(i);
        end
      end
    end else if (win_vld || !bus.req_valid[aged_q]) begin
      state_d = ST_RR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RR;
      aged_q      <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      err_q       <= '0;
      held_q      <= '0;
      lock_busy_q <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
      for (int p = 0; p < PATH_LEN; p++) owner_q[p] <= '0;
    end else if (bus.flush) begin
      state_q     <= ST_RR;
      grant_q     <= '0;
      err_q       <= '0;
      held_q      <= '0;
      lock_busy_q <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
      for (int p = 0; p < PATH_LEN; p++) owner_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      aged_q      <= aged_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      held_q      <= held_d;
      lock_busy_q <= lock_busy_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      owner_q     <= owner_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.err         = err_q;
  assign bus.held        = held_q;
  assign bus.lock_busy   = lock_busy_q;
  assign bus.grant_count = cnt_q;
endmodule

// File: tb/tb_path_lock_arbiter.sv
// Bench for path_lock_arbiter: directed scenarios plus randomized traffic vs. a set-based model.
module tb_path_lock_arbiter;
  import tsp_pkg::*;
  localparam int N = 4;
  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_lock_arbiter_if #(.N_REQ(N)) bus();
  path_lock_arbiter #(.N_REQ(N), .MAX_WAIT(MAXW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Model: who owns each position (-1 free), holders, waits, rr pointer, aged requester (-1 none).
  int          m_owner [64];
  bit          m_held  [N];
  int          m_wait  [N];
  int          m_rr;
  int          m_aged;
  logic [31:0] m_cnt;
  logic [N-1:0] e_grant, e_err;
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] pos_set(bit mode, int v1, int v2);
    logic [63:0] s;
    s = '0;
    if (mode) begin
      for (int k = 0; k < 4; k++) s[(v1 + k) % 64] = 1'b1;
    end else begin
      for (int d = -1; d <= 1; d++) begin
        s[(v1 + d + 64) % 64] = 1'b1;
        s[(v2 + d + 64) % 64] = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic bit pair_invalid(int v1, int v2);
    return (v1 == v2) || (v2 == (v1 + 1) % 64) || (v1 == (v2 + 1) % 64);
  endfunction

  function automatic logic [63:0] m_busy();
    logic [63:0] b;
    for (int p = 0; p < 64; p++) b[p] = (m_owner[p] != -1);
    return b;
  endfunction

  function automatic logic [N-1:0] m_heldv();
    logic [N-1:0] h;
    for (int i = 0; i < N; i++) h[i] = m_held[i];
    return h;
  endfunction

  task automatic model_clear(bit keep_rr);
    for (int p = 0; p < 64; p++) m_owner[p] = -1;
    for (int i = 0; i < N; i++) begin m_held[i] = 0; m_wait[i] = 0; end
    if (!keep_rr) m_rr = 0;
    m_aged = -1;
    m_cnt = '0;
    e_grant = '0;
    e_err = '0;
  endtask

  task automatic model_step();
    logic [63:0] s [N];
    bit inv [N];
    bit elig [N];
    bit hp [N];
    int win, prev;
    bit free;
    e_grant = '0;
    e_err = '0;
    if (bus.flush) begin
      model_clear(1'b1);
      return;
    end
    for (int i = 0; i < N; i++) begin
      s[i]   = pos_set(bus.req_mode[i], int'(bus.req_v1[i]), int'(bus.req_v2[i]));
      inv[i] = !bus.req_mode[i] && pair_invalid(int'(bus.req_v1[i]), int'(bus.req_v2[i]));
      hp[i]  = m_held[i];
      free = 1;
      for (int p = 0; p < 64; p++) if (s[i][p] && m_owner[p] != -1) free = 0;
      elig[i] = bus.req_valid[i] && !hp[i] && !inv[i] && free;
      e_err[i] = bus.req_valid[i] && !hp[i] && inv[i];
    end
    prev = m_aged;
    win = -1;
    if (prev < 0) begin
      for (int k = 0; k < N; k++) if (win < 0 && elig[(m_rr + k) % N]) win = (m_rr + k) % N;
    end else if (elig[prev]) begin
      win = prev;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.rel_valid[i] && hp[i]) begin
        for (int p = 0; p < 64; p++) if (m_owner[p] == i) m_owner[p] = -1;
        m_held[i] = 0;
      end
    end
    if (win >= 0) begin
      for (int p = 0; p < 64; p++) if (s[win][p]) m_owner[p] = win;
      m_held[win] = 1;
      m_cnt = m_cnt + 1;
      e_grant[win] = 1'b1;
      if (prev < 0) m_rr = (win + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i] || hp[i] || inv[i] || i == win) m_wait[i] = 0;
      else if (m_wait[i] < MAXW) m_wait[i]++;
    end
    if (prev < 0) begin
      for (int i = N - 1; i >= 0; i--) if (m_wait[i] == MAXW) m_aged = i;
    end else if (win >= 0 || !bus.req_valid[prev]) begin
      m_aged = -1;
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("grant", 64'(bus.grant), 64'(e_grant));
    check("err", 64'(bus.err), 64'(e_err));
    check("held", 64'(bus.held), 64'(m_heldv()));
    check("lock_busy", bus.lock_busy, m_busy());
    check("grant_count", 64'(bus.grant_count), 64'(m_cnt));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    bus.flush = 1'b0;
    bus.req_valid = '0;
    bus.req_mode = '0;
    bus.req_v1 = '0;
    bus.req_v2 = '0;
    bus.rel_valid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear(1'b0);
    compare_all();
  endtask

  task automatic req(int i, bit mode, int v1, int v2);
    bus.req_valid[i] = 1'b1;
    bus.req_mode[i]  = mode;
    bus.req_v1[i]    = 6'(v1);
    bus.req_v2[i]    = 6'(v2);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_busy", bus.lock_busy, 64'd0);
    check("rst_count", 64'(bus.grant_count), 64'd0);

    // Basic pair grant
    req(0, 0, 10, 20);
    cycle();
    check("pair_grant", 64'(bus.grant), 64'h1);
    check("pair_busy", bus.lock_busy, 64'h0000_0000_0038_0E00);
    check("pair_held", 64'(bus.held), 64'h1);
    check("pair_count", 64'(bus.grant_count), 64'd1);
    bus.req_valid[0] = 1'b0;
    bus.rel_valid[0] = 1'b1;
    cycle();
    bus.rel_valid[0] = 1'b0;
    check("pair_release", bus.lock_busy, 64'd0);

    // Wrap-around window and blocked pair released later
    req(1, 1, 62, 0);
    cycle();
    check("wrap_grant", 64'(bus.grant), 64'h2);
    check("wrap_busy", bus.lock_busy, 64'hC000_0000_0000_0003);
    bus.req_valid[1] = 1'b0;
    req(2, 0, 0, 30);
    repeat (3) begin
      cycle();
      check("blocked_grant", 64'(bus.grant), 64'd0);
    end
    bus.rel_valid[1] = 1'b1;
    cycle();
    bus.rel_valid[1] = 1'b0;
    check("rel_cycle_grant", 64'(bus.grant), 64'd0);
    cycle();
    check("after_rel_grant", 64'(bus.grant), 64'h4);
    bus.req_valid[2] = 1'b0;

    // Invalid pairs
    req(3, 0, 5, 6);
    cycle();
    check("inv_err", 64'(bus.err), 64'h8);
    check("inv_held", 64'(bus.held), 64'h4);
    req(3, 0, 63, 0);
    cycle();
    check("inv_wrap_err", 64'(bus.err), 64'h8);
    bus.req_valid[3] = 1'b0;
    cycle();
    check("inv_cleared", 64'(bus.err), 64'd0);

    // Round robin from reset, then flush
    do_reset();
    for (int i = 0; i < N; i++) req(i, 1, 8 * i, 0);
    for (int c = 0; c < N; c++) begin
      cycle();
      check("rr_order", 64'(bus.grant), 64'(1 << c));
      bus.req_valid[c] = 1'b0;
    end
    check("rr_count", 64'(bus.grant_count), 64'd4);
    bus.rel_valid[3] = 1'b1;
    cycle();
    bus.rel_valid[3] = 1'b0;
    req(3, 1, 0, 0);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    check("flush_busy", bus.lock_busy, 64'd0);
    check("flush_held", 64'(bus.held), 64'd0);
    check("flush_count", 64'(bus.grant_count), 64'd0);
    check("flush_grant", 64'(bus.grant), 64'd0);
    cycle();
    check("post_flush_grant", 64'(bus.grant), 64'h8);
    bus.req_valid[3] = 1'b0;

    // Aging: requester 1 starves behind requester 0 while 2 and 3 churn
    do_reset();
    req(0, 0, 10, 40);
    cycle();
    bus.req_valid[0] = 1'b0;
    req(1, 1, 10, 0);
    for (int c = 0; c < 30; c++) begin
      for (int r = 2; r < 4; r++) begin
        if (m_held[r]) begin
          bus.req_valid[r] = 1'b0;
          bus.rel_valid[r] = 1'b1;
        end else begin
          bus.rel_valid[r] = 1'b0;
          req(r, 1, (r == 2) ? 20 : 30, 0);
        end
      end
      cycle();
    end
    bus.rel_valid = '0;
    for (int r = 2; r < 4; r++) req(r, 1, (r == 2) ? 20 : 30, 0);
    repeat (3) begin
      cycle();
      check("aged_holdoff", 64'(bus.grant), 64'd0);
      check("aged_held", 64'(bus.held), 64'h1);
    end
    bus.rel_valid[0] = 1'b1;
    cycle();
    bus.rel_valid[0] = 1'b0;
    check("aged_rel_cycle", 64'(bus.grant), 64'd0);
    cycle();
    check("aged_grant", 64'(bus.grant), 64'h2);
    bus.req_valid[1] = 1'b0;
    cycle();
    check("back_to_rr", 64'(|bus.grant[3:2]), 64'd1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
        continue;
      end
      bus.flush = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        bus.rel_valid[i] = 1'b0;
        if (m_held[i]) begin
          bus.req_valid[i] = 1'b0;
          if ($urandom_range(0, 5) == 0) bus.rel_valid[i] = 1'b1;
        end else if (bus.req_valid[i]) begin
          if (e_err[i] && $urandom_range(0, 2) != 0) bus.req_valid[i] = 1'b0;
          else if ($urandom_range(0, 30) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          int v1, v2;
          v1 = $urandom_range(0, 63);
          case ($urandom_range(0, 7))
            0: v2 = v1;
            1: v2 = (v1 + 1) % 64;
            default: v2 = $urandom_range(0, 63);
          endcase
          req(i, 1'($urandom_range(0, 1)), v1, v2);
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
